// File: rtl/serial_tx_pkg.sv
// serial_tx_pkg: shared constants and helpers for the multi-lane serializer.
// Holds the PRBS7 generator definition used by the optional PRBS filler
// (enabled with SERIAL_TX_PRBS_FILL_EN) and the beat-counter width helper.
package serial_tx_pkg;

  // PRBS7 polynomial x^7 + x^6 + 1: feedback is state[6] ^ state[5].
  localparam logic [6:0] PRBS7_SEED = 7'h7F;
  localparam logic [6:0] PRBS7_TAPS = 7'b110_0000;

  // Upper bound on the number of PRBS bits produced in one call.
  localparam int PRBS_MAX_W = 512;

  typedef struct packed {
    logic [6:0]            state;
    logic [PRBS_MAX_W-1:0] bits;   // earliest bit at bits[nsteps-1], latest at bits[0]
  } prbs7_res_t;

  // Advance the LFSR nsteps times; return the new state and the emitted bits.
  function automatic prbs7_res_t prbs7_adv(input logic [6:0] state, input int nsteps);
    prbs7_res_t r;
    logic [6:0] s;
    logic       b;
    s      = state;
    r.bits = '0;
    for (int i = 0; i < PRBS_MAX_W; i++) begin
      if (i < nsteps) begin
        b      = ^(s & PRBS7_TAPS);
        s      = {s[5:0], b};
        r.bits = {r.bits[PRBS_MAX_W-2:0], b};
      end
    end
    r.state = s;
    return r;
  endfunction

  // Ceiling log2, with a minimum result of 1 so counters are never zero-width.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/serial_tx_lanes_prbs7.sv
// serial_tx_prbs7: W-bit-per-step PRBS7 filler source.
// Q shows the next W PRBS bits (earliest bit in Q[W-1]) combinationally from the
// current state, so it is valid in the same cycle ADV is asserted; the state
// advances by W steps on that edge. Only instantiated under SERIAL_TX_PRBS_FILL_EN.
module serial_tx_prbs7
  import serial_tx_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         ADV,
  output logic [W-1:0] Q
);

  if (W >= PRBS_MAX_W) begin : g_bad_width
    $error("serial_tx_prbs7: W must be smaller than PRBS_MAX_W");
  end

  prbs7_res_t nxt;
  logic [6:0] state;
  logic       unused_bits;

  // Next W bits and the state that follows them.
  always_comb nxt = prbs7_adv(state, W);

  assign Q           = nxt.bits[W-1:0];
  assign unused_bits = ^nxt.bits[PRBS_MAX_W-1:W];

  // LFSR state only moves when a filler word is consumed.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)      state <= PRBS7_SEED;
    else if (ADV) state <= nxt.state;
  end

endmodule

// File: rtl/serial_tx_lanes.sv
// serial_tx_lanes: W-bit word serializer emitting LANES bits per clock.
// Words are taken over VALID/READY once every N = W/LANES cycles; when no word
// is offered a filler word is sent instead so the line never stalls.
// Define SERIAL_TX_PRBS_FILL_EN to use PRBS7 filler instead of IDLE_WORD.
module serial_tx_lanes
  import serial_tx_pkg::*;
#(
  parameter int           W         = 64,
  parameter int           LANES     = 2,
  parameter bit           MSB_FIRST = 1'b1,
  parameter logic [W-1:0] IDLE_WORD = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [W-1:0]     DIN,
  input  logic             VALID,
  output logic             READY,
  output logic [LANES-1:0] DOUT,
  output logic             FRAME,
  output logic             DATA_BEAT,
  output logic [15:0]      WORD_CNT
);

  if (((W % LANES) != 0) || ((W / LANES) < 2)) begin : g_bad_params
    $error("serial_tx_lanes: W must be a multiple of LANES with W/LANES >= 2");
  end

  localparam int            N    = W / LANES;
  localparam int            CW   = clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0] cnt;
  logic [W-1:0]  shift;
  logic [W-1:0]  shift_nxt;
  logic [W-1:0]  filler;

  // A new word is taken on the edge that ends the last beat of the current one.
  assign READY = (cnt == LAST);

  if (MSB_FIRST) begin : g_msb
    assign DOUT      = shift[W-1 -: LANES];
    assign shift_nxt = shift << LANES;
  end else begin : g_lsb
    assign DOUT      = shift[LANES-1:0];
    assign shift_nxt = shift >> LANES;
  end

`ifdef SERIAL_TX_PRBS_FILL_EN
  logic [W-1:0] prbs_q;
  logic         prbs_adv;

  assign prbs_adv = READY && !VALID;

  serial_tx_prbs7 #(.W(W)) u_prbs (
    .CLK (CLK),
    .RST (RST),
    .ADV (prbs_adv),
    .Q   (prbs_q)
  );

  // Earliest PRBS bit must land at the end of the word that leaves first.
  if (MSB_FIRST) begin : g_fill_msb
    assign filler = prbs_q;
  end else begin : g_fill_lsb
    for (genvar i = 0; i < W; i++) begin : g_rev
      assign filler[i] = prbs_q[W-1-i];
    end
  end
`else
  assign filler = IDLE_WORD;
`endif

  // Beat counter, shift register, word flags and accepted-word counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shift     <= '0;
      cnt       <= LAST;
      FRAME     <= 1'b0;
      DATA_BEAT <= 1'b0;
      WORD_CNT  <= '0;
    end else if (READY) begin
      cnt   <= '0;
      FRAME <= 1'b1;
      if (VALID) begin
        shift     <= DIN;
        DATA_BEAT <= 1'b1;
        WORD_CNT  <= WORD_CNT + 16'd1;
      end else begin
        shift     <= filler;
        DATA_BEAT <= 1'b0;
      end
    end else begin
      shift <= shift_nxt;
      cnt   <= cnt + CW'(1);
      FRAME <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_tx_lanes.sv
// tb_serial_tx_lanes: self-checking bench for serial_tx_lanes (W=16, LANES=2).
// Expected streams are built from a per-slot word list: after reset release a
// word slot starts every N cycles, and each slot's word is emitted MSB-first,
// two bits per beat. Filler is zero, or the PRBS7 reference sequence when
// SERIAL_TX_PRBS_FILL_EN is defined.
module tb_serial_tx_lanes;

  localparam int W     = 16;
  localparam int LANES = 2;
  localparam int N     = W / LANES;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  logic [W-1:0]     din = '0, din_l = '0;
  logic             valid = 1'b0, valid_l = 1'b0;
  logic             ready, ready_l;
  logic [LANES-1:0] dout, dout_l;
  logic             frame, frame_l, data_beat, data_beat_l;
  logic [15:0]      word_cnt, word_cnt_l;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] words[$];
  bit           isdata[$];
  bit           prbs_seq[127];
  int           prbs_pos;

  always #5 CLK = ~CLK;

  serial_tx_lanes #(.W(W), .LANES(LANES), .MSB_FIRST(1'b1), .IDLE_WORD(16'h0000)) dut (
    .CLK(CLK), .RST(RST), .DIN(din), .VALID(valid), .READY(ready), .DOUT(dout),
    .FRAME(frame), .DATA_BEAT(data_beat), .WORD_CNT(word_cnt)
  );

  serial_tx_lanes #(.W(W), .LANES(LANES), .MSB_FIRST(1'b0), .IDLE_WORD(16'h0000)) dut_lsb (
    .CLK(CLK), .RST(RST), .DIN(din_l), .VALID(valid_l), .READY(ready_l), .DOUT(dout_l),
    .FRAME(frame_l), .DATA_BEAT(data_beat_l), .WORD_CNT(word_cnt_l)
  );

  function automatic logic [W-1:0] next_filler();
    logic [W-1:0] w;
    w = '0;
`ifdef SERIAL_TX_PRBS_FILL_EN
    for (int i = 0; i < W; i++) begin
      w        = {w[W-2:0], prbs_seq[prbs_pos]};
      prbs_pos = (prbs_pos + 1) % 127;
    end
`endif
    return w;
  endfunction

  task automatic add_slot(input bit d, input logic [W-1:0] wd);
    if (d) begin
      words.push_back(wd);
      isdata.push_back(1'b1);
    end else begin
      words.push_back(next_filler());
      isdata.push_back(1'b0);
    end
  endtask

  // Leaves the bench at cycle 0 (+1ns) after release, with the model cleared.
  task automatic apply_reset();
    @(negedge CLK);
    RST     = 1'b1;
    valid   = 1'b0;
    valid_l = 1'b0;
    repeat (2) @(negedge CLK);
    RST      = 1'b0;
    prbs_pos = 0;
    words.delete();
    isdata.delete();
    #1;
  endtask

  // Checks cycles 0..ncycles-1 against the slot list, driving each slot's word
  // in its READY cycle. Non-READY cycles carry junk (or the next word if hold).
  task automatic run_stream(input string name, input int ncycles, input bit hold);
    int nslots, wc, j, b, s;
    logic [W-1:0]     w;
    logic [LANES-1:0] e_dout;
    logic             e_frame, e_db, e_ready;
    nslots = words.size();
    wc     = 0;
    for (int c = 0; c < ncycles; c++) begin
      if (c == 0) begin
        e_dout = '0; e_frame = 1'b0; e_db = 1'b0;
      end else begin
        j = (c - 1) / N;
        b = (c - 1) % N;
        w = words[j];
        e_dout  = w[W-1-LANES*b -: LANES];
        e_frame = (b == 0);
        e_db    = isdata[j];
        if (b == 0 && isdata[j]) wc++;
      end
      e_ready = ((c % N) == 0);
      n_tests += 5;
      if (dout !== e_dout) begin
        n_fail++; $display("FAIL %s dout c=%0d got=%b exp=%b", name, c, dout, e_dout);
      end
      if (frame !== e_frame) begin
        n_fail++; $display("FAIL %s frame c=%0d got=%b exp=%b", name, c, frame, e_frame);
      end
      if (data_beat !== e_db) begin
        n_fail++; $display("FAIL %s data_beat c=%0d got=%b exp=%b", name, c, data_beat, e_db);
      end
      if (word_cnt !== 16'(wc)) begin
        n_fail++; $display("FAIL %s word_cnt c=%0d got=%0d exp=%0d", name, c, word_cnt, wc);
      end
      if (ready !== e_ready) begin
        n_fail++; $display("FAIL %s ready c=%0d got=%b exp=%b", name, c, ready, e_ready);
      end
      if ((c % N) == 0) begin
        s = c / N;
        valid = (s < nslots) ? isdata[s] : 1'b0;
        din   = (s < nslots && isdata[s]) ? words[s] : W'($urandom);
      end else if (hold) begin
        s = c / N + 1;
        valid = (s < nslots) ? isdata[s] : 1'b0;
        din   = (s < nslots) ? words[s] : '0;
      end else begin
        valid = 1'($urandom_range(0, 1));
        din   = W'($urandom);
      end
      @(negedge CLK);
      #1;
    end
    valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    RST = 1'b1;
    #1;
    n_tests += 5;
    if (dout !== 2'b00)     begin n_fail++; $display("FAIL reset dout got=%b exp=00", dout); end
    if (frame !== 1'b0)     begin n_fail++; $display("FAIL reset frame got=%b exp=0", frame); end
    if (data_beat !== 1'b0) begin n_fail++; $display("FAIL reset data_beat got=%b exp=0", data_beat); end
    if (word_cnt !== 16'd0) begin n_fail++; $display("FAIL reset word_cnt got=%0d exp=0", word_cnt); end
    if (ready !== 1'b1)     begin n_fail++; $display("FAIL reset ready got=%b exp=1", ready); end
  endtask

  task automatic test_idle_fill();
    apply_reset();
    for (int i = 0; i < 4; i++) add_slot(1'b0, '0);
    run_stream("idle_fill", 4 * N + 1, 1'b0);
  endtask

  task automatic test_known_word();
    apply_reset();
    add_slot(1'b1, 16'hA5C3);
    add_slot(1'b0, '0);
    run_stream("known_word", 2 * N + 1, 1'b0);
  endtask

  task automatic test_back_to_back();
    apply_reset();
    add_slot(1'b1, 16'h1234);
    add_slot(1'b1, 16'hFFFF);
    add_slot(1'b1, 16'h8001);
    add_slot(1'b0, '0);
    run_stream("back_to_back", 4 * N + 1, 1'b1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      apply_reset();
      for (int i = 0; i < 10; i++) add_slot(1'($urandom_range(0, 1)), W'($urandom));
      run_stream("random", 10 * N + 1, 1'(r & 1));
    end
  endtask

  task automatic test_fill_resume();
    apply_reset();
    for (int i = 0; i < 4; i++) add_slot(1'b0, '0);
    add_slot(1'b1, 16'h3C96);
    for (int i = 0; i < 4; i++) add_slot(1'b0, '0);
    run_stream("fill_resume", 9 * N + 1, 1'b0);
  endtask

  task automatic test_lsb_first();
    apply_reset();
    n_tests++;
    if (ready_l !== 1'b1) begin n_fail++; $display("FAIL lsb ready got=%b exp=1", ready_l); end
    din_l   = 16'h0001;
    valid_l = 1'b1;
    @(negedge CLK); #1;
    valid_l = 1'b0;
    din_l   = 16'hFFFF;
    for (int b = 0; b < N; b++) begin
      n_tests += 3;
      if (dout_l !== ((b == 0) ? 2'b01 : 2'b00)) begin
        n_fail++; $display("FAIL lsb dout beat=%0d got=%b exp=%b", b, dout_l, (b == 0) ? 2'b01 : 2'b00);
      end
      if (frame_l !== (b == 0)) begin
        n_fail++; $display("FAIL lsb frame beat=%0d got=%b", b, frame_l);
      end
      if (data_beat_l !== 1'b1) begin
        n_fail++; $display("FAIL lsb data_beat beat=%0d got=%b exp=1", b, data_beat_l);
      end
      @(negedge CLK); #1;
    end
    n_tests++;
    if (word_cnt_l !== 16'd1) begin n_fail++; $display("FAIL lsb word_cnt got=%0d exp=1", word_cnt_l); end
  endtask

  task automatic test_mid_word_reset();
    apply_reset();
    add_slot(1'b1, 16'hA5C3);
    run_stream("mid_reset_pre", 4, 1'b0);
    n_tests++;
    if (dout !== 2'b01) begin n_fail++; $display("FAIL mid_reset beat3 dout got=%b exp=01", dout); end
    RST = 1'b1;
    #1;
    n_tests += 4;
    if (dout !== 2'b00)     begin n_fail++; $display("FAIL mid_reset dout got=%b exp=00", dout); end
    if (frame !== 1'b0)     begin n_fail++; $display("FAIL mid_reset frame got=%b exp=0", frame); end
    if (data_beat !== 1'b0) begin n_fail++; $display("FAIL mid_reset data_beat got=%b exp=0", data_beat); end
    if (word_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_reset word_cnt got=%0d exp=0", word_cnt); end
    @(negedge CLK);
    RST = 1'b0;
    #1;
    n_tests++;
    if (ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset ready_after got=%b exp=1", ready); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] s;
    s = 7'h7F;
    for (int i = 0; i < 127; i++) begin
      prbs_seq[i] = s[6] ^ s[5];
      s = {s[5:0], prbs_seq[i]};
    end
    test_reset();
    test_idle_fill();
    test_known_word();
    test_back_to_back();
    test_lsb_first();
    test_mid_word_reset();
    test_fill_resume();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
